// File: rtl/sc_datamem_io_ctrl.sv
// Data memory plus memory-mapped I/O for the single-cycle CPU: byte-enabled writes, registered
// reads with a valid strobe, synchronised inputs with sticky change flags and a maskable irq.
module sc_datamem_io_ctrl #(
  parameter int unsigned IO_SEL_BIT = 7,
  parameter int unsigned DMEM_AW    = 5,
  parameter int unsigned N_OUT      = 3,
  parameter int unsigned N_IN       = 2,
  parameter int unsigned IN_W       = 5
) (
  input  logic                    clock,
  input  logic                    clrn,
  input  logic [31:0]             addr,
  input  logic [31:0]             datain,
  input  logic                    we,
  input  logic                    re,
  input  logic [3:0]              be,
  output logic [31:0]             dataout,
  output logic                    rvalid,
  output logic [32*N_OUT-1:0]     out_port,
  input  logic [IN_W*N_IN-1:0]    in_port,
  output logic                    irq
);

  localparam int unsigned Depth     = 1 << DMEM_AW;
  localparam int unsigned OffInBase = 16;
  localparam logic [4:0]  OffMask   = 5'd30;
  localparam logic [4:0]  OffStatus = 5'd31;

  // Address decode
  logic               io_sel;
  logic [4:0]         io_off;
  logic [DMEM_AW-1:0] mem_idx;
  logic [31:0]        bmask;
  logic               mem_wr;
  logic               io_wr;
  logic               io_rd;
  logic               unused_addr;

  assign io_sel      = addr[IO_SEL_BIT];
  assign io_off      = addr[6:2];
  assign mem_idx     = addr[DMEM_AW+1:2];
  assign mem_wr      = we & ~io_sel;
  assign io_wr       = we & io_sel;
  assign io_rd       = re & io_sel;
  assign unused_addr = ^addr;

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 4; i++) begin
      bmask[8*i +: 8] = {8{be[i]}};
    end
  end

  // Data memory; contents deliberately not reset
  logic [31:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (mem_wr) begin
      mem[mem_idx] <= (mem[mem_idx] & ~bmask) | (datain & bmask);
    end
  end

  // Output port registers
  logic [31:0] out_q [N_OUT];

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      for (int k = 0; k < N_OUT; k++) begin
        out_q[k] <= '0;
      end
    end else if (io_wr) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (io_off == 5'(k)) begin
          out_q[k] <= (out_q[k] & ~bmask) | (datain & bmask);
        end
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_port[32*g +: 32] = out_q[g];
  end

  // Input synchronisers and previous-sample register
  logic [IN_W*N_IN-1:0] sync1_q;
  logic [IN_W*N_IN-1:0] sync2_q;
  logic [IN_W*N_IN-1:0] prev_q;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Change flags, mask and interrupt
  logic [N_IN-1:0] flags_q, flags_d;
  logic [N_IN-1:0] mask_q, mask_d;
  logic [N_IN-1:0] flag_set;
  logic [N_IN-1:0] flag_clr;
  logic            irq_d;

  always_comb begin
    flag_set = '0;
    for (int k = 0; k < N_IN; k++) begin
      flag_set[k] = sync2_q[IN_W*k +: IN_W] != prev_q[IN_W*k +: IN_W];
    end
  end

  // Set wins over a same-edge read-to-clear so no event is lost
  assign flag_clr = {N_IN{io_rd && (io_off == OffStatus)}};
  assign flags_d  = (flags_q & ~flag_clr) | flag_set;
  assign mask_d   = (io_wr && (io_off == OffMask) && be[0]) ? datain[N_IN-1:0] : mask_q;
  assign irq_d    = |(flags_d & mask_d);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      flags_q <= '0;
      mask_q  <= '0;
      irq     <= 1'b0;
    end else begin
      flags_q <= flags_d;
      mask_q  <= mask_d;
      irq     <= irq_d;
    end
  end

  // Read mux
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (!io_sel) begin
      rdata = mem[mem_idx];
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (io_off == 5'(k)) begin
          rdata = out_q[k];
        end
      end
      for (int k = 0; k < N_IN; k++) begin
        if (io_off == 5'(OffInBase + k)) begin
          rdata[IN_W-1:0] = sync2_q[IN_W*k +: IN_W];
        end
      end
      if (io_off == OffMask) begin
        rdata[N_IN-1:0] = mask_q;
      end
      if (io_off == OffStatus) begin
        rdata[N_IN-1:0] = flags_q;
      end
    end
  end

  // Registered read response; nonblocking capture yields pre-write data on a same-word write
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      dataout <= '0;
      rvalid  <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        dataout <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_sc_datamem_io_ctrl.sv
// Directed bench for sc_datamem_io_ctrl: a vector table for memory/port accesses, plus
// hand-written sequences for reset, input synchronisation, flags and irq timing.
module tb_sc_datamem_io_ctrl;

  logic        clock;
  logic        clrn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic        re;
  logic [3:0]  be;
  logic [31:0] dataout;
  logic        rvalid;
  logic [95:0] out_port;
  logic [9:0]  in_port;
  logic        irq;

  int n_total;
  int n_pass;

  sc_datamem_io_ctrl dut (
    .clock    (clock),
    .clrn     (clrn),
    .addr     (addr),
    .datain   (datain),
    .we       (we),
    .re       (re),
    .be       (be),
    .dataout  (dataout),
    .rvalid   (rvalid),
    .out_port (out_port),
    .in_port  (in_port),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_rv;
    logic [31:0] exp_dout;
    int          port;
    logic [31:0] exp_port;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one request, let one rising edge pass, return 1 time unit after it
  task automatic cycle(input logic w, input logic r, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    we = w; re = r; addr = a; be = b; datain = d;
    @(posedge clock);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d, input logic rv,
                              input logic [31:0] dout, input int p, input logic [31:0] pv);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.be = b; v.wdata = d;
    v.exp_rv = rv; v.exp_dout = dout; v.port = p; v.exp_port = pv;
    return v;
  endfunction

  initial begin
    n_total = 0; n_pass = 0;
    we = 0; re = 0; addr = 0; be = 0; datain = 0; in_port = '0;

    vecs[0]  = mk(1, 0, 32'h0C, 4'hF, 32'h11223344, 0, 32'h0, -1, 0);
    vecs[1]  = mk(1, 0, 32'h0C, 4'h5, 32'hAABBCCDD, 0, 32'h0, -1, 0);
    vecs[2]  = mk(0, 1, 32'h0C, 4'h0, 32'h0,        1, 32'h11BB33DD, -1, 0);
    vecs[3]  = mk(0, 0, 32'h0,  4'h0, 32'h0,        0, 32'h11BB33DD, -1, 0);
    vecs[4]  = mk(0, 1, 32'h8C, 4'h0, 32'h0,        1, 32'h0, -1, 0);
    vecs[5]  = mk(1, 1, 32'h84, 4'hF, 32'h12345678, 1, 32'h0, 1, 32'h12345678);
    vecs[6]  = mk(0, 1, 32'h84, 4'h0, 32'h0,        1, 32'h12345678, 1, 32'h12345678);
    vecs[7]  = mk(1, 0, 32'h88, 4'h3, 32'hCAFEF00D, 0, 32'h12345678, 2, 32'h0000F00D);
    vecs[8]  = mk(0, 1, 32'h88, 4'h0, 32'h0,        1, 32'h0000F00D, 2, 32'h0000F00D);
    vecs[9]  = mk(1, 0, 32'hC0, 4'hF, 32'hFFFFFFFF, 0, 32'h0000F00D, 0, 32'h0);
    vecs[10] = mk(0, 1, 32'hC0, 4'h0, 32'h0,        1, 32'h0, -1, 0);
    vecs[11] = mk(1, 0, 32'h90, 4'hF, 32'hFFFFFFFF, 0, 32'h0, -1, 0);
    vecs[12] = mk(0, 1, 32'h90, 4'h0, 32'h0,        1, 32'h0, -1, 0);
    vecs[13] = mk(1, 0, 32'h7C, 4'hF, 32'hA5A5A5A5, 0, 32'h0, -1, 0);
    vecs[14] = mk(0, 1, 32'h7C, 4'h0, 32'h0,        1, 32'hA5A5A5A5, -1, 0);
    vecs[15] = mk(1, 0, 32'h8C, 4'hF, 32'h99999999, 0, 32'hA5A5A5A5, -1, 0);
    vecs[16] = mk(0, 1, 32'h0C, 4'h0, 32'h0,        1, 32'h11BB33DD, -1, 0);
    vecs[17] = mk(0, 1, 32'hF8, 4'h0, 32'h0,        1, 32'h0, -1, 0);

    // Power-on reset
    clrn = 1'b1;
    #1 clrn = 1'b0;
    @(posedge clock);
    #1;
    check("por_dataout", dataout, 32'h0);
    check("por_rvalid", {31'b0, rvalid}, 32'h0);
    check("por_irq", {31'b0, irq}, 32'h0);
    check("por_out_port", out_port[31:0] | out_port[63:32] | out_port[95:64], 32'h0);
    clrn = 1'b1;

    // Asynchronous reset between edges
    cycle(1, 1, 32'h80, 4'hF, 32'hDEADBEEF);
    check("pre_rst_port0", out_port[31:0], 32'hDEADBEEF);
    check("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
    #2 clrn = 1'b0;
    #1;
    check("async_rst_port0", out_port[31:0], 32'h0);
    check("async_rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clock);
    #1 clrn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      check($sformatf("vec%0d_rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].exp_rv});
      check($sformatf("vec%0d_dataout", i), dataout, vecs[i].exp_dout);
      if (vecs[i].port >= 0)
        check($sformatf("vec%0d_port%0d", i, vecs[i].port),
              out_port[32*vecs[i].port +: 32], vecs[i].exp_port);
    end

    // Input lane 0 held at 0x15
    in_port = {5'h00, 5'h15};
    repeat (4) cycle(0, 0, 32'h0, 4'h0, 32'h0);
    cycle(0, 1, 32'hC0, 4'h0, 32'h0);
    check("in0_read", dataout, 32'h15);
    check("in0_irq_masked", {31'b0, irq}, 32'h0);
    cycle(0, 1, 32'hFC, 4'h0, 32'h0);
    check("status_flag0", dataout, 32'h1);
    cycle(0, 1, 32'hFC, 4'h0, 32'h0);
    check("status_flag0_cleared", dataout, 32'h0);
    cycle(1, 0, 32'hF8, 4'h1, 32'h2);
    cycle(0, 1, 32'hF8, 4'h0, 32'h0);
    check("mask_read", dataout, 32'h2);
    cycle(1, 0, 32'hF8, 4'hE, 32'h0);
    cycle(0, 1, 32'hF8, 4'h0, 32'h0);
    check("mask_be0_gated", dataout, 32'h2);

    // Lane 1 change: flag and irq appear at the third edge
    in_port = {5'h0A, 5'h15};
    cycle(0, 0, 32'h0, 4'h0, 32'h0);
    check("irq_edge1", {31'b0, irq}, 32'h0);
    cycle(0, 0, 32'h0, 4'h0, 32'h0);
    check("irq_edge2", {31'b0, irq}, 32'h0);
    cycle(0, 0, 32'h0, 4'h0, 32'h0);
    check("irq_edge3", {31'b0, irq}, 32'h1);
    cycle(0, 1, 32'hFC, 4'h0, 32'h0);
    check("status_flag1", dataout, 32'h2);
    check("status_flag1_rvalid", {31'b0, rvalid}, 32'h1);
    cycle(0, 0, 32'h0, 4'h0, 32'h0);
    check("irq_after_clear", {31'b0, irq}, 32'h0);
    cycle(0, 1, 32'hFC, 4'h0, 32'h0);
    check("status_second_read", dataout, 32'h0);

    // Set and read-to-clear on the same edge: set wins
    in_port = {5'h0B, 5'h15};
    cycle(0, 0, 32'h0, 4'h0, 32'h0);
    cycle(0, 0, 32'h0, 4'h0, 32'h0);
    cycle(0, 1, 32'hFC, 4'h0, 32'h0);
    check("setwins_read_pre", dataout, 32'h0);
    check("setwins_irq", {31'b0, irq}, 32'h1);
    cycle(0, 1, 32'hFC, 4'h0, 32'h0);
    check("setwins_flag_kept", dataout, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule
